// File: rtl/stm_pkg.sv
// stm_pkg: shared focus-STM frame size and per-transducer beat type
package stm_pkg;

    localparam int DEPTH = 249;

    typedef struct packed {
        logic [7:0] intensity;
        logic [7:0] phase;
    } beat_t;

endpackage

// File: rtl/stm_buf_ram.sv
// stm_buf_ram: two-bank simple dual-port beat RAM, addressed {bank, idx}, registered read
module stm_buf_ram
    import stm_pkg::*;
#(
    parameter int ABITS = 9
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  beat_t            wdata_i,
    input  logic [ABITS-1:0] raddr_i,
    output beat_t            rdata_o
);

    beat_t mem_q [2**ABITS];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/stm_drive_buffer.sv
// stm_drive_buffer: double-buffered STM frame capture; banks swap on UPDATE only when a full frame is held
module stm_drive_buffer
    import stm_pkg::*;
#(
    parameter int DEPTH = stm_pkg::DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          DIN_VALID,
    input  logic [7:0]    INTENSITY_IN,
    input  logic [7:0]    PHASE_IN,
    input  logic          UPDATE,
    input  logic [AW-1:0] RD_IDX,
    output logic [7:0]    RD_INTENSITY,
    output logic [7:0]    RD_PHASE,
    output logic          FRAME_READY,
    output logic          SWAPPED,
    output logic          UNDERRUN,
    input  logic          CLEAR_ERR
);

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic          wr_bank_q, wr_bank_d;
    logic [AW:0]   wr_idx_q, wr_idx_d;
    logic          frame_ready_q, frame_ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic          underrun_q, underrun_d;
    logic          swapped_q;
    logic          rd_ok_q;
    logic          we, last_wr, done, swap;
    logic [AW-1:0] widx;
    beat_t         rdata;

    // START restarts the frame in the same cycle, so a coincident beat lands at index 0
    always_comb begin
        widx          = START ? '0 : wr_idx_q[AW-1:0];
        we            = DIN_VALID && (START || wr_idx_q < FULL);
        last_wr       = we && ({1'b0, widx} == LAST);
        done          = frame_ready_q || last_wr;
        swap          = UPDATE && done;
        wr_bank_d     = wr_bank_q ^ swap;
        wr_idx_d      = swap ? '0 : START ? {{AW{1'b0}}, DIN_VALID} : we ? wr_idx_q + 1'b1 : wr_idx_q;
        frame_ready_d = swap ? 1'b0 : last_wr ? 1'b1 : START ? 1'b0 : frame_ready_q;
        rd_valid_d    = rd_valid_q || swap;
        underrun_d    = (UPDATE && !done) || (underrun_q && !CLEAR_ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_bank_q     <= 1'b1;
            wr_idx_q      <= '0;
            frame_ready_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            swapped_q     <= 1'b0;
            rd_ok_q       <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            wr_idx_q      <= wr_idx_d;
            frame_ready_q <= frame_ready_d;
            rd_valid_q    <= rd_valid_d;
            underrun_q    <= underrun_d;
            swapped_q     <= swap;
            rd_ok_q       <= rd_valid_q && ({1'b0, RD_IDX} < FULL);
        end
    end

    stm_buf_ram #(.ABITS(AW + 1)) u_ram (
        .clk_i   (CLK),
        .we_i    (we),
        .waddr_i ({wr_bank_q, widx}),
        .wdata_i ({INTENSITY_IN, PHASE_IN}),
        .raddr_i ({~wr_bank_q, RD_IDX}),
        .rdata_o (rdata)
    );

    // RAM contents are undefined until the first swap; the gate is cleared asynchronously
    assign RD_INTENSITY = rd_ok_q ? rdata.intensity : '0;
    assign RD_PHASE     = rd_ok_q ? rdata.phase : '0;
    assign FRAME_READY  = frame_ready_q;
    assign SWAPPED      = swapped_q;
    assign UNDERRUN     = underrun_q;

endmodule

// File: tb/tb_stm_drive_buffer.sv
// tb_stm_drive_buffer: scoreboard bench for stm_drive_buffer swap, underrun and read gating
module tb_stm_drive_buffer;
    import stm_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RST, START, DIN_VALID, UPDATE, CLEAR_ERR;
    logic [7:0]    INTENSITY_IN, PHASE_IN, RD_INTENSITY, RD_PHASE;
    logic [AW-1:0] RD_IDX;
    logic          FRAME_READY, SWAPPED, UNDERRUN;

    int          n_cmp, n_bad;
    logic [15:0] wb [DEPTH];
    logic [15:0] rb [DEPTH];
    int          widx;
    bit          fr, rv, ur;
    logic [15:0] exp_q [$];

    always #5 CLK = ~CLK;

    stm_drive_buffer dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .DIN_VALID    (DIN_VALID),
        .INTENSITY_IN (INTENSITY_IN),
        .PHASE_IN     (PHASE_IN),
        .UPDATE       (UPDATE),
        .RD_IDX       (RD_IDX),
        .RD_INTENSITY (RD_INTENSITY),
        .RD_PHASE     (RD_PHASE),
        .FRAME_READY  (FRAME_READY),
        .SWAPPED      (SWAPPED),
        .UNDERRUN     (UNDERRUN),
        .CLEAR_ERR    (CLEAR_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] beat_val(input int mode, input int i);
        return mode == 0 ? {8'(i), 8'(255 - i)} :
               mode == 1 ? 16'hAAAA :
               mode == 2 ? {8'(i) ^ 8'h5A, 8'(i)} :
                           {8'(i >> 1), 8'(i)};
    endfunction

    task automatic apply_upd(input bit done, input bit clr);
        if (!done) ur = 1'b1;
        else begin
            rb   = wb;
            rv   = 1'b1;
            widx = 0;
            fr   = 1'b0;
            if (clr) ur = 1'b0;
        end
    endtask

    task automatic send(input int n, input int mode, input bit upd_last, input bit start_first);
        bit          done;
        logic [15:0] v;
        done = 1'b0;
        for (int j = 0; j < n; j++) begin
            v      = beat_val(mode, j);
            START  = start_first && j == 0;
            UPDATE = upd_last && j == n - 1;
            if (START) begin
                widx = 0;
                fr   = 1'b0;
            end
            DIN_VALID = 1'b1;
            {INTENSITY_IN, PHASE_IN} = v;
            done = fr || widx == DEPTH - 1;
            if (widx < DEPTH) begin
                wb[widx] = v;
                widx++;
                if (widx == DEPTH) fr = 1'b1;
            end
            step;
            if (UPDATE) apply_upd(done, 1'b0);
        end
        START = 1'b0;
        UPDATE = 1'b0;
        DIN_VALID = 1'b0;
        if (upd_last) chk("swapped_on_last", SWAPPED, done);
        chk("frame_ready", FRAME_READY, fr);
        chk("underrun", UNDERRUN, ur);
    endtask

    task automatic upd(input bit clr);
        bit done;
        done = fr;
        UPDATE = 1'b1;
        CLEAR_ERR = clr;
        step;
        UPDATE = 1'b0;
        CLEAR_ERR = 1'b0;
        apply_upd(done, clr);
        chk("swapped", SWAPPED, done);
        chk("underrun_upd", UNDERRUN, ur);
        chk("frame_ready_upd", FRAME_READY, fr);
    endtask

    task automatic clear;
        CLEAR_ERR = 1'b1;
        step;
        CLEAR_ERR = 1'b0;
        ur = 1'b0;
        chk("underrun_clear", UNDERRUN, ur);
    endtask

    task automatic rd(input int idx);
        logic [15:0] e;
        RD_IDX = AW'(idx);
        exp_q.push_back((rv && idx < DEPTH) ? rb[idx] : 16'h0);
        step;
        e = exp_q.pop_front();
        chk($sformatf("rd_int[%0d]", idx), RD_INTENSITY, e[15:8]);
        chk($sformatf("rd_pha[%0d]", idx), RD_PHASE, e[7:0]);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        widx = 0; fr = 0; rv = 0; ur = 0;
        RST = 1'b1; START = 1'b0; DIN_VALID = 1'b0; UPDATE = 1'b0; CLEAR_ERR = 1'b0;
        INTENSITY_IN = '0; PHASE_IN = '0; RD_IDX = '0;
        step;
        chk("rst_rd_int", RD_INTENSITY, 0);
        chk("rst_rd_pha", RD_PHASE, 0);
        chk("rst_frame_ready", FRAME_READY, 0);
        chk("rst_swapped", SWAPPED, 0);
        chk("rst_underrun", UNDERRUN, 0);
        RST = 1'b0;
        rd(0);
        rd(100);
        // full frame, then swap
        send(DEPTH, 0, 1'b0, 1'b0);
        upd(1'b0);
        rd(0);
        rd(100);
        rd(248);
        chk("swapped_pulse_end", SWAPPED, 0);
        // underrun after a partial frame, completion, then swap
        send(100, 2, 1'b0, 1'b0);
        upd(1'b0);
        rd(100);
        send(DEPTH - 100, 2, 1'b0, 1'b0);
        upd(1'b0);
        rd(100);
        rd(248);
        clear;
        // UPDATE coincident with the final beat
        send(DEPTH, 0, 1'b1, 1'b0);
        rd(248);
        // overflow beats are dropped without error
        send(260, 3, 1'b0, 1'b0);
        upd(1'b0);
        rd(0);
        rd(1);
        rd(248);
        // abandoned partial frame, restart with START plus first beat
        send(50, 0, 1'b0, 1'b0);
        START = 1'b1;
        step;
        START = 1'b0;
        widx = 0;
        fr = 1'b0;
        chk("start_clears_ready", FRAME_READY, fr);
        send(DEPTH, 1, 1'b0, 1'b1);
        upd(1'b0);
        for (int i = 0; i < DEPTH; i++) rd(i);
        rd(249);
        rd(255);
        // asynchronous reset mid-frame
        send(30, 0, 1'b0, 1'b0);
        rd(3);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("async_rd_int", RD_INTENSITY, 0);
        chk("async_rd_pha", RD_PHASE, 0);
        chk("async_frame_ready", FRAME_READY, 0);
        chk("async_underrun", UNDERRUN, 0);
        rv = 1'b0; widx = 0; fr = 1'b0; ur = 1'b0;
        step;
        RST = 1'b0;
        rd(3);
        upd(1'b0);
        upd(1'b1);
        clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stm_drive_buffer.md
# stm_drive_buffer

Double-buffered capture stage directly downstream of the focus-STM calculator. Collects the 249-beat per-transducer intensity/phase stream for one STM sample into a write bank and exposes a stable read bank to the drive/PWM stage. Banks swap only on an explicit UPDATE strobe, and only when a complete frame has been captured. The drive side therefore never sees a half-written frame.

## Interface
Parameters:
- DEPTH, 249: transducers per frame (beats per frame).
- AW, $clog2(DEPTH): read/write index width.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  reset, asynchronous and active-high.
- START  in  1  one-cycle pulse; a new frame begins; write index cleared.
- DIN_VALID  in  1  input beat valid; no backpressure.
- INTENSITY_IN  in  8  beat intensity.
- PHASE_IN  in  8  beat phase.
- UPDATE  in  1  one-cycle swap request from the timing controller.
- RD_IDX  in  AW  transducer index for the read bank.
- RD_INTENSITY  out  8  read-bank intensity at RD_IDX, registered.
- RD_PHASE  out  8  read-bank phase at RD_IDX, registered.
- FRAME_READY  out  1  write bank holds a complete frame.
- SWAPPED  out  1  one-cycle pulse; a swap took effect.
- UNDERRUN  out  1  sticky; UPDATE arrived without a complete frame.
- CLEAR_ERR  in  1  clears UNDERRUN.

## Operation
- State: wr_bank (1 bit), wr_idx (AW+1 bits), FRAME_READY, rd_valid (read bank has ever been loaded).
- Reset values:
  - wr_bank=1, so the read bank is 0.
  - wr_idx=0, FRAME_READY=0, rd_valid=0.
  - All outputs 0.
- Write path:
  - While wr_idx<DEPTH, each DIN_VALID beat writes {INTENSITY_IN, PHASE_IN} to bank wr_bank at wr_idx, then wr_idx increments.
  - When the beat at index DEPTH-1 is written, FRAME_READY is set on the next edge.
  - Beats arriving with wr_idx==DEPTH are discarded silently. They do not raise an error.
- START:
  - Clears wr_idx and FRAME_READY; any partial frame is abandoned.
  - START together with DIN_VALID: the beat is written at index 0 and wr_idx becomes 1.
- UPDATE, frame complete: if FRAME_READY is 1, or the current cycle writes index DEPTH-1, the following happens on the same edge:
  - wr_bank toggles.
  - wr_idx←0, FRAME_READY←0, rd_valid←1.
  - SWAPPED pulses on the next cycle.
  - A DEPTH-1 write in that cycle lands in the old write bank, which becomes the new read bank.
- UPDATE, frame incomplete:
  - No swap; the read bank is unchanged.
  - UNDERRUN←1. The write in progress continues unaffected.
- CLEAR_ERR:
  - Clears UNDERRUN.
  - If CLEAR_ERR and a new underrun occur in the same cycle, set wins.
- Read path:
  - RD_INTENSITY/RD_PHASE are registered from bank ~wr_bank at RD_IDX.
  - Outputs are 0 if rd_valid=0 or RD_IDX≥DEPTH.
- Reset mid-frame: all state returns to reset values; memory contents are don't-care because rd_valid gates the outputs.

## Timing
- Write: a beat is committed at the edge where DIN_VALID=1.
- Back-to-back beats are supported at 1 beat/cycle. The upstream calculator emits DEPTH beats on consecutive cycles.
- Read latency: 1 cycle from RD_IDX to RD_*.
- Bank-select change: read data reflects the new bank for RD_IDX sampled on the cycle after the swap edge. This is the same cycle SWAPPED is high.
- Minimum UPDATE-to-UPDATE spacing for a swap each time: DEPTH beats plus one.
- FRAME_READY rises 1 cycle after the last beat's edge.

## Structure
- Shared package stm_pkg holds:
  - DEPTH (shared with the focus calculator and drive stage).
  - the {intensity, phase} beat struct typedef.
- One sub-module, stm_buf_ram:
  - simple dual-port RAM, 2×DEPTH×16.
  - write port: {bank, idx}; read port: {bank, idx} with registered output.
  - infers distributed RAM.
- Control, counters and flags live in the top.

## Test plan
- Reset, then DEPTH beats with intensity=i, phase=255-i, then UPDATE → SWAPPED pulse. Reading RD_IDX=0/100/248 after 1 cycle gives (0,255)/(100,155)/(248,7). UNDERRUN=0.
- UPDATE after only 100 beats → no SWAPPED, UNDERRUN=1, read bank unchanged. After 149 more beats, UPDATE → swap. CLEAR_ERR → UNDERRUN=0.
- UPDATE in the same cycle as beat 248 → swap occurs and RD_IDX=248 returns beat 248.
- 260 consecutive beats → first 249 stored, extra 11 dropped, FRAME_READY=1, no error. Before the first swap, any RD_IDX reads 0.
- START after 50 beats, then a full frame of value 0xAA → swap shows 0xAA at every index. RD_IDX=249 reads 0.
- Assert RST mid-frame with a loaded read bank → outputs 0 immediately (async). After release, UPDATE alone → UNDERRUN=1.
